// File: rtl/reg_file_ctrl.sv
// ============================================================================
//  Module   : reg_file_ctrl
//  Purpose  : Byte-stream command front-end for register_file (write/read
//             frames in, WrEn/RdEn strobes out, read data returned on tx port).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_ctrl #(
    parameter int          ADDR_WIDTH = 3,
    parameter int          MEM_DEPTH  = 8,
    parameter int          MEM_WIDTH  = 16,
    parameter logic [7:0]  CMD_WR     = 8'hAA,
    parameter logic [7:0]  CMD_RD     = 8'hBB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [MEM_WIDTH-1:0]  WrData,
    input  logic [MEM_WIDTH-1:0]  RdData,
    output logic [MEM_WIDTH-1:0]  tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  err
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        W_ADDR = 4'd1,
        W_DLO  = 4'd2,
        W_DHI  = 4'd3,
        WRITE  = 4'd4,
        R_ADDR = 4'd5,
        READ   = 4'd6,
        R_WAIT = 4'd7,
        SEND   = 4'd8
    } state_t;

    // Address bytes are compared at 9 bits so any MEM_DEPTH up to 256 fits.
    localparam logic [8:0] DEPTH_LIMIT = 9'(MEM_DEPTH);

    state_t state;
    logic   accept;
    logic   addr_bad;

    assign rx_ready = (state == IDLE)  || (state == W_ADDR) || (state == W_DLO) ||
                      (state == W_DHI) || (state == R_ADDR);
    assign accept   = rx_valid && rx_ready;
    assign addr_bad = ({1'b0, rx_data} >= DEPTH_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            address  <= '0;
            WrData   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Strobes and err are single-cycle pulses unless re-armed below.
            WrEn <= 1'b0;
            RdEn <= 1'b0;
            err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (rx_data == CMD_WR) begin
                            state <= W_ADDR;
                        end else if (rx_data == CMD_RD) begin
                            state <= R_ADDR;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                W_ADDR: begin
                    if (accept) begin
                        if (addr_bad) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            address <= rx_data[ADDR_WIDTH-1:0];
                            state   <= W_DLO;
                        end
                    end
                end

                W_DLO: begin
                    if (accept) begin
                        WrData[7:0] <= rx_data;
                        state       <= W_DHI;
                    end
                end

                W_DHI: begin
                    if (accept) begin
                        WrData[15:8] <= rx_data;
                        WrEn         <= 1'b1;
                        state        <= WRITE;
                    end
                end

                WRITE: begin
                    state <= IDLE;
                end

                R_ADDR: begin
                    if (accept) begin
                        if (addr_bad) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            address <= rx_data[ADDR_WIDTH-1:0];
                            RdEn    <= 1'b1;
                            state   <= READ;
                        end
                    end
                end

                READ: begin
                    state <= R_WAIT;
                end

                // register_file presents RdData during this cycle.
                R_WAIT: begin
                    tx_data  <= RdData;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end

                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_ctrl.sv
// ============================================================================
//  Module   : tb_reg_file_ctrl
//  Purpose  : Scoreboard bench for reg_file_ctrl with a behavioural register_file.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        WrEn;
    logic        RdEn;
    logic [2:0]  address;
    logic [15:0] WrData;
    logic [15:0] RdData;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        err;

    int assertions  = 0;
    int failures    = 0;
    int overlap_cnt = 0;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] rq[$];
    logic [15:0] sb_mem [0:7];
    logic [15:0] rf_mem [0:7];

    reg_file_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .WrEn     (WrEn),
        .RdEn     (RdEn),
        .address  (address),
        .WrData   (WrData),
        .RdData   (RdData),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register_file: read data appears one clock after RdEn.
    always @(posedge clk) begin
        if (WrEn && !RdEn) rf_mem[address] <= WrData;
        if (RdEn && !WrEn) RdData <= rf_mem[address];
    end

    always @(negedge clk) begin
        if (WrEn && RdEn) overlap_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            assertions++; failures++;
            $display("FAIL rx_accept: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic write_frame(input logic [2:0] a, input logic [15:0] d);
        wr_t e;
        wq.push_back('{a: a, d: d});
        sb_mem[a] = d;
        send_byte(8'hAA);
        send_byte({5'd0, a});
        send_byte(d[7:0]);
        send_byte(d[15:8]);
        @(negedge clk);
        e = wq.pop_front();
        assertions++;
        if (WrEn !== 1'b1 || RdEn !== 1'b0 || address !== e.a || WrData !== e.d) begin
            failures++;
            $display("FAIL write_strobe: WrEn=%b RdEn=%b addr=%0d data=%h required 1 0 %0d %h",
                     WrEn, RdEn, address, WrData, e.a, e.d);
        end
        @(negedge clk);
        assertions++;
        if (WrEn !== 1'b0) begin
            failures++;
            $display("FAIL write_one_cycle: WrEn=%b required 0", WrEn);
        end
    endtask

    task automatic read_frame(input logic [2:0] a, input int hold, input bit check_lat);
        logic [15:0] exp;
        int cnt;
        rq.push_back(sb_mem[a]);
        tx_ready = (hold == 0);
        send_byte(8'hBB);
        send_byte({5'd0, a});
        @(negedge clk);
        assertions++;
        if (RdEn !== 1'b1 || WrEn !== 1'b0 || address !== a) begin
            failures++;
            $display("FAIL read_strobe: RdEn=%b WrEn=%b addr=%0d required 1 0 %0d", RdEn, WrEn, address, a);
        end
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (check_lat && cnt == 1) begin
                assertions++;
                if (RdEn !== 1'b0 || tx_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL read_one_cycle: RdEn=%b tx_valid=%b required 0 0", RdEn, tx_valid);
                end
            end
        end while (!tx_valid && cnt < 20);
        exp = rq.pop_front();
        assertions++;
        if (tx_valid !== 1'b1 || tx_data !== exp) begin
            failures++;
            $display("FAIL read_data: tx_valid=%b tx_data=%h required 1 %h", tx_valid, tx_data, exp);
        end
        if (check_lat) begin
            assertions++;
            if (cnt != 2) begin
                failures++;
                $display("FAIL read_latency: tx_valid after %0d cycles past RdEn, required 2", cnt);
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            assertions++;
            if (tx_valid !== 1'b1 || tx_data !== exp || rx_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold: tx_valid=%b tx_data=%h rx_ready=%b required 1 %h 0",
                         tx_valid, tx_data, rx_ready, exp);
            end
        end
        tx_ready = 1'b1;
        @(negedge clk);
        assertions++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_release: tx_valid=%b rx_ready=%b required 0 1", tx_valid, rx_ready);
        end
    endtask

    task automatic test_reset();
        int wr_seen;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        assertions++;
        if (WrEn !== 0 || RdEn !== 0 || address !== 0 || WrData !== 0 ||
            tx_data !== 0 || tx_valid !== 0 || err !== 0) begin
            failures++;
            $display("FAIL reset_outputs: WrEn=%b RdEn=%b addr=%0d WrData=%h tx_data=%h tx_valid=%b err=%b required all 0",
                     WrEn, RdEn, address, WrData, tx_data, tx_valid, err);
        end
        rst = 1'b1;
        @(negedge clk);
        assertions++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_rx_ready: rx_ready=%b required 1", rx_ready);
        end
        send_byte(8'hAA);
        send_byte(8'h02);
        @(negedge clk);
        assertions++;
        if (address !== 3'd2) begin
            failures++;
            $display("FAIL pre_reset_addr: address=%0d required 2", address);
        end
        rst = 1'b0;
        #1;
        assertions++;
        if (address !== 0 || WrEn !== 0 || RdEn !== 0 || err !== 0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL midframe_reset: addr=%0d WrEn=%b RdEn=%b err=%b rx_ready=%b required 0 0 0 0 1",
                     address, WrEn, RdEn, err, rx_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        wr_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (WrEn || RdEn) wr_seen++;
        end
        assertions++;
        if (wr_seen != 0) begin
            failures++;
            $display("FAIL reset_abort: %0d strobe cycles after release, required 0", wr_seen);
        end
    endtask

    task automatic test_write();
        write_frame(3'd3, 16'hA93C);
    endtask

    task automatic test_read_back();
        read_frame(3'd3, 0, 1'b1);
    endtask

    task automatic test_back_pressure();
        write_frame(3'd7, 16'h1234);
        read_frame(3'd7, 5, 1'b0);
    endtask

    task automatic test_errors();
        int wr_seen;
        send_byte(8'h55);
        @(negedge clk);
        assertions++;
        if (err !== 1'b1 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL bad_cmd_err: err=%b rx_ready=%b required 1 1", err, rx_ready);
        end
        @(negedge clk);
        assertions++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse_width: err=%b required 0", err);
        end
        send_byte(8'hAA);
        send_byte(8'h08);
        @(negedge clk);
        assertions++;
        if (err !== 1'b1 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL bad_addr_err: err=%b rx_ready=%b required 1 1", err, rx_ready);
        end
        wr_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (WrEn || err) wr_seen++;
        end
        assertions++;
        if (wr_seen != 0) begin
            failures++;
            $display("FAIL bad_addr_drop: %0d WrEn/err cycles after drop, required 0", wr_seen);
        end
        write_frame(3'd1, 16'hFFFF);
        read_frame(3'd1, 0, 1'b0);
    endtask

    task automatic test_exclusivity();
        for (int i = 0; i < 8; i++) write_frame(3'(i), 16'($urandom));
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 0)
                write_frame(3'($urandom_range(0, 7)), 16'($urandom));
            else
                read_frame(3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b0);
        end
        assertions++;
        if (overlap_cnt != 0 || wq.size() != 0 || rq.size() != 0) begin
            failures++;
            $display("FAIL exclusivity: overlap=%0d wq=%0d rq=%0d required 0 0 0",
                     overlap_cnt, wq.size(), rq.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_back();
        test_back_pressure();
        test_errors();
        test_exclusivity();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

`default_nettype wire
